// File: rtl/display_bcd_ctrl_if.sv
// Request/result bundle between the ALU result register, the BCD display
// controller and the display multiplexer.
interface display_bcd_ctrl_if #(
   parameter int unsigned NB_DATA = 8
);
   logic               i_valid;
   logic [NB_DATA-1:0] i_data;
   logic               i_signed;
   logic               o_busy;
   logic               o_done;
   logic [6:0]         o_seg0;
   logic [6:0]         o_seg1;
   logic [6:0]         o_seg2;
   logic [6:0]         o_seg3;

   modport master (
      output i_valid, i_data, i_signed,
      input  o_busy, o_done, o_seg0, o_seg1, o_seg2, o_seg3
   );

   modport slave (
      input  i_valid, i_data, i_signed,
      output o_busy, o_done, o_seg0, o_seg1, o_seg2, o_seg3
   );
endinterface

// File: rtl/display_bcd_ctrl.sv
// Converts one ALU result to four active-low 7-segment codes using a
// sequential double-dabble, with sign and leading-zero blanking.
module display_bcd_ctrl #(
   parameter int unsigned NB_DATA  = 8,
   parameter bit          LZ_BLANK = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   display_bcd_ctrl_if.slave bus
);
   localparam int unsigned CW        = $clog2(NB_DATA + 1);
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;
   localparam logic [6:0]  SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_ENCODE,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic               neg, neg_n;
   logic [NB_DATA-1:0] mag, mag_n;
   logic [11:0]        bcd, bcd_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [6:0]         seg0, seg1, seg2, seg3;
   logic [6:0]         seg0_n, seg1_n, seg2_n, seg3_n;
   logic [NB_DATA:0]   mag_in;
   logic [11:0]        bcd_adj;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_IDLE;
         neg   <= 1'b0;
         mag   <= '0;
         bcd   <= '0;
         cnt   <= '0;
         seg0  <= SEG_BLANK;
         seg1  <= SEG_BLANK;
         seg2  <= SEG_BLANK;
         seg3  <= SEG_BLANK;
      end else begin
         state <= state_n;
         neg   <= neg_n;
         mag   <= mag_n;
         bcd   <= bcd_n;
         cnt   <= cnt_n;
         seg0  <= seg0_n;
         seg1  <= seg1_n;
         seg2  <= seg2_n;
         seg3  <= seg3_n;
      end
   end

   always_comb begin
      state_n = state;
      neg_n   = neg;
      mag_n   = mag;
      bcd_n   = bcd;
      cnt_n   = cnt;
      seg0_n  = seg0;
      seg1_n  = seg1;
      seg2_n  = seg2;
      seg3_n  = seg3;
      mag_in  = '0;
      bcd_adj = bcd;

      case (state)
         S_IDLE: begin
            if (bus.i_valid) begin
               neg_n  = bus.i_signed & bus.i_data[NB_DATA-1];
               mag_in = neg_n ? ({1'b0, ~bus.i_data} + 1'b1) : {1'b0, bus.i_data};
               // The magnitude MSB (weight 2^NB_DATA, always 0 for legal inputs) is
               // preloaded as an already-shifted bit, so NB_DATA shifts cover all bits.
               {bcd_n, mag_n} = {11'd0, mag_in};
               cnt_n   = '0;
               state_n = S_SHIFT;
            end
         end

         S_SHIFT: begin
            for (int unsigned i = 0; i < 3; i++) begin
               if (bcd[4*i +: 4] >= 4'd5)
                  bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
            {bcd_n, mag_n} = {bcd_adj, mag} << 1;
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(NB_DATA - 1))
               state_n = S_ENCODE;
         end

         S_ENCODE: begin
            seg0_n = seg7(bcd[3:0]);
            seg1_n = (LZ_BLANK && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0)
                     ? SEG_BLANK : seg7(bcd[7:4]);
            seg2_n = (LZ_BLANK && bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
            seg3_n = neg ? SEG_MINUS : SEG_BLANK;
            state_n = S_DONE;
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign bus.o_busy = (state != S_IDLE);
   assign bus.o_done = (state == S_DONE);
   assign bus.o_seg0 = seg0;
   assign bus.o_seg1 = seg1;
   assign bus.o_seg2 = seg2;
   assign bus.o_seg3 = seg3;
endmodule
